// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and the queued-write record for the write-back port arbiter.
package wb_port_arbiter_pkg;
    localparam int DW   = 8;
    localparam int RW   = 2;
    localparam int NREG = 1 << RW;

    localparam logic SRC_MEM = 1'b1;
    localparam logic SRC_AC  = 1'b0;

    // src only travels along for debug visibility on the rf side
    typedef struct packed {
        logic          src;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back request / register-file write bundle between the pipeline and the arbiter.
interface wb_port_arbiter_if #(parameter int DEPTH = 4);
    import wb_port_arbiter_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;

    logic            ac_we;
    logic [RW-1:0]   ac_rd;
    logic [DW-1:0]   ac_data;
    logic            mem_we;
    logic [RW-1:0]   mem_rd;
    logic [DW-1:0]   mem_data;

    logic            rf_we;
    logic [RW-1:0]   rf_rd;
    logic [DW-1:0]   rf_data;
    logic            rf_src;
    logic            stall;
    logic [NREG-1:0] pend;
    logic [CW-1:0]   fifo_cnt;
    logic            overflow;

    modport master (
        output ac_we, ac_rd, ac_data, mem_we, mem_rd, mem_data,
        input  rf_we, rf_rd, rf_data, rf_src, stall, pend, fifo_cnt, overflow
    );

    modport slave (
        input  ac_we, ac_rd, ac_data, mem_we, mem_rd, mem_data,
        output rf_we, rf_rd, rf_data, rf_src, stall, pend, fifo_cnt, overflow
    );
endinterface

// File: rtl/wb_fifo.sv
// In-order queue of losing write-backs; two ordered push ports, one pop, entry rd fields exposed.
module wb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_push0,
    input  wb_entry_t     i_push0_entry,
    input  logic          i_push1,
    input  wb_entry_t     i_push1_entry,
    input  logic          i_pop,
    output wb_entry_t     o_head,
    output logic [CW-1:0] o_count,
    output logic [RW-1:0] o_entry_rd [DEPTH],
    output logic [DEPTH-1:0] o_valid
);
    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_wr_ptr1;
    logic [PW-1:0] w_wr_ptr2;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_wr_ptr1 = ptr_inc(r_wr_ptr);
    assign w_wr_ptr2 = ptr_inc(w_wr_ptr1);

    // push1 is only ever used together with push0, so it lands one slot past the tail
    always_ff @(posedge i_clock) begin
        if (i_push0) r_mem[r_wr_ptr]  <= i_push0_entry;
        if (i_push1) r_mem[w_wr_ptr1] <= i_push1_entry;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push1)      r_wr_ptr <= w_wr_ptr2;
            else if (i_push0) r_wr_ptr <= w_wr_ptr1;
            if (i_pop)        r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
        end
    end

    always_comb begin
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_entry_rd[i] = r_mem[i].rd;
            o_valid[i] = (((i + DEPTH - int'(r_rd_ptr)) % DEPTH) < int'(r_count));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the memory-load and ALU write-back paths,
// with an in-order overflow queue, back-pressure and a per-register pending scoreboard.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic               i_clock,
    input logic               i_reset,
    wb_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t       w_head;
    logic [CW-1:0]   w_count;
    logic [RW-1:0]   w_entry_rd [DEPTH];
    logic [DEPTH-1:0] w_valid;

    logic            w_stall;
    logic            w_empty;
    logic            w_mem_acc;
    logic            w_ac_acc;
    wb_entry_t       w_mem_e;
    wb_entry_t       w_ac_e;

    logic            w_grant;
    wb_entry_t       w_grant_e;
    logic            w_pop;
    logic            w_push0;
    wb_entry_t       w_push0_e;
    logic            w_push1;
    wb_entry_t       w_push1_e;
    logic [NREG-1:0] w_pend;

    logic            r_rf_we;
    logic [RW-1:0]   r_rf_rd;
    logic [DW-1:0]   r_rf_data;
    logic            r_rf_src;
    logic            r_overflow;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_push0       (w_push0),
        .i_push0_entry (w_push0_e),
        .i_push1       (w_push1),
        .i_push1_entry (w_push1_e),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_count       (w_count),
        .o_entry_rd    (w_entry_rd),
        .o_valid       (w_valid)
    );

    assign w_empty   = (w_count == '0);
    assign w_stall   = (w_count >= CW'(DEPTH - 1));
    assign w_mem_acc = bus.mem_we & ~w_stall;
    assign w_ac_acc  = bus.ac_we  & ~w_stall;
    assign w_mem_e   = '{src: SRC_MEM, rd: bus.mem_rd, data: bus.mem_data};
    assign w_ac_e    = '{src: SRC_AC,  rd: bus.ac_rd,  data: bus.ac_data};

    // Oldest first: queue head, then mem, then ac; losers go to the tail in that order.
    always_comb begin
        w_grant   = 1'b0;
        w_grant_e = '0;
        w_pop     = 1'b0;
        w_push0   = 1'b0;
        w_push0_e = '0;
        w_push1   = 1'b0;
        w_push1_e = '0;
        if (!w_empty) begin
            w_grant   = 1'b1;
            w_grant_e = w_head;
            w_pop     = 1'b1;
            if (w_mem_acc) begin
                w_push0   = 1'b1;
                w_push0_e = w_mem_e;
                if (w_ac_acc) begin
                    w_push1   = 1'b1;
                    w_push1_e = w_ac_e;
                end
            end else if (w_ac_acc) begin
                w_push0   = 1'b1;
                w_push0_e = w_ac_e;
            end
        end else if (w_mem_acc) begin
            w_grant   = 1'b1;
            w_grant_e = w_mem_e;
            if (w_ac_acc) begin
                w_push0   = 1'b1;
                w_push0_e = w_ac_e;
            end
        end else if (w_ac_acc) begin
            w_grant   = 1'b1;
            w_grant_e = w_ac_e;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_data  <= '0;
            r_rf_src   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rf_we <= w_grant;
            if (w_grant) begin
                r_rf_rd   <= w_grant_e.rd;
                r_rf_data <= w_grant_e.data;
                r_rf_src  <= w_grant_e.src;
            end
            if (w_stall && (bus.mem_we || bus.ac_we)) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) w_pend[w_entry_rd[i]] = 1'b1;
        end
        if (r_rf_we) w_pend[r_rf_rd] = 1'b1;
    end

    assign bus.rf_we    = r_rf_we;
    assign bus.rf_rd    = r_rf_rd;
    assign bus.rf_data  = r_rf_data;
    assign bus.rf_src   = r_rf_src;
    assign bus.stall    = w_stall;
    assign bus.pend     = w_pend;
    assign bus.fifo_cnt = w_count;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter: a program-order reference model
// feeds an expected-write queue that a negedge monitor drains against the rf port.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic          src;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Model: m_* is what the DUT should show this cycle, n_* what it should show next cycle.
    wr_t           m_fq[$];
    wr_t           n_fq[$];
    bit            m_rf_we, n_rf_we;
    logic [RW-1:0] m_rf_rd, n_rf_rd;
    logic [DW-1:0] m_rf_data, n_rf_data;
    bit            m_ovf, n_ovf;
    wr_t           exp_q[$];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int seq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances by the spec's rules:
    // accepted requests join the program-order backlog, and the oldest backlog item commits.
    task automatic step(input bit r, input bit mw, input int mrd, input int md,
                        input bit aw, input int ard, input int ad);
        wr_t cand[$];
        wr_t w;
        bit  stall_now;
        @(posedge clk);
        #1;
        m_fq      = n_fq;
        m_rf_we   = n_rf_we;
        m_rf_rd   = n_rf_rd;
        m_rf_data = n_rf_data;
        m_ovf     = n_ovf;
        chk_en    = 1'b1;

        rst          = r;
        bus.mem_we   = mw;
        bus.mem_rd   = mrd[RW-1:0];
        bus.mem_data = md[DW-1:0];
        bus.ac_we    = aw;
        bus.ac_rd    = ard[RW-1:0];
        bus.ac_data  = ad[DW-1:0];

        stall_now = (m_fq.size() >= DEPTH - 1);
        if (r) begin
            repeat (m_fq.size()) void'(exp_q.pop_back());
            n_fq.delete();
            n_rf_we   = 1'b0;
            n_rf_rd   = '0;
            n_rf_data = '0;
            n_ovf     = 1'b0;
        end else begin
            cand = m_fq;
            if (!stall_now) begin
                if (mw) begin
                    w = '{src: 1'b1, rd: mrd[RW-1:0], data: md[DW-1:0]};
                    cand.push_back(w);
                    exp_q.push_back(w);
                end
                if (aw) begin
                    w = '{src: 1'b0, rd: ard[RW-1:0], data: ad[DW-1:0]};
                    cand.push_back(w);
                    exp_q.push_back(w);
                end
            end else if (mw || aw) begin
                n_ovf = 1'b1;
            end
            if (cand.size() > 0) begin
                w = cand.pop_front();
                n_rf_we   = 1'b1;
                n_rf_rd   = w.rd;
                n_rf_data = w.data;
            end else begin
                n_rf_we = 1'b0;
            end
            n_fq = cand;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic both_next();
        seq += 2;
        step(0, 1, $urandom_range(0, NREG - 1), seq, 1, $urandom_range(0, NREG - 1), seq + 1);
    endtask

    always @(negedge clk) begin
        logic [NREG-1:0] p;
        wr_t e;
        if (chk_en) begin
            p = '0;
            foreach (m_fq[i]) p[m_fq[i].rd] = 1'b1;
            if (m_rf_we) p[m_rf_rd] = 1'b1;
            chk("rf_we",    32'(bus.rf_we),    32'(m_rf_we));
            chk("rf_rd",    32'(bus.rf_rd),    32'(m_rf_rd));
            chk("rf_data",  32'(bus.rf_data),  32'(m_rf_data));
            chk("fifo_cnt", 32'(bus.fifo_cnt), 32'(m_fq.size()));
            chk("stall",    32'(bus.stall),    32'(m_fq.size() >= DEPTH - 1));
            chk("pend",     32'(bus.pend),     32'(p));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_write actual rd=%0d data=%0h required none t=%0t",
                             bus.rf_rd, bus.rf_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_rd",   32'(bus.rf_rd),   32'(e.rd));
                    chk("sb_data", 32'(bus.rf_data), 32'(e.data));
                    chk("sb_src",  32'(bus.rf_src),  32'(e.src));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit mw, aw;
        n_fq.delete();
        n_rf_we = 0; n_rf_rd = '0; n_rf_data = '0; n_ovf = 0;
        bus.mem_we = 0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.ac_we  = 0; bus.ac_rd  = '0; bus.ac_data  = '0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        step(0, 0, 0, 0, 1, 2, 8'h5A);
        idle(3);

        step(0, 1, 1, 8'h11, 1, 3, 8'h33);
        idle(3);

        step(0, 1, 0, 8'hAA, 1, 0, 8'hBB);
        idle(3);

        repeat (8) begin
            if (n_fq.size() < DEPTH - 1) both_next();
            else idle(1);
        end
        idle(6);

        while (n_fq.size() < DEPTH - 1) both_next();
        step(0, 0, 0, 0, 1, 1, 8'h77);
        idle(6);

        while (n_fq.size() < DEPTH - 1) both_next();
        step(1, 1, 2, 8'h99, 1, 3, 8'h98);
        idle(4);

        repeat (400) begin
            mw = ($urandom_range(0, 99) < 55);
            aw = ($urandom_range(0, 99) < 55);
            if (n_fq.size() >= DEPTH - 1 && $urandom_range(0, 3) != 0) begin
                mw = 0;
                aw = 0;
            end
            seq += 2;
            step(($urandom_range(0, 99) == 0), mw, $urandom_range(0, NREG - 1), seq,
                 aw, $urandom_range(0, NREG - 1), seq + 1);
        end

        idle(DEPTH + 4);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Schedules the single register-file write port between two write-back sources: the accumulator/ALU path and the memory-load path.
- Loser writes are buffered in a small in-order FIFO, and back-pressure is given to the pipeline.
- Exports a per-register pending scoreboard for hazard detection.
- Sits between the write-back stage and the register file; the register file's write enable, address and data come only from this block.

Parameters:
- DW, 8, data width of a register write.
- RW, 2, register index width (2^RW registers).
- DEPTH, 4, FIFO entries; legal range 2..16.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ac_we  in  1  ALU-path write request.
- ac_rd  in  RW  ALU-path destination register.
- ac_data  in  DW  ALU-path result.
- mem_we  in  1  memory-path write request.
- mem_rd  in  RW  memory-path destination register.
- mem_data  in  DW  memory-path load data.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  RW  register-file write address (registered).
- rf_data  out  DW  register-file write data (registered).
- stall  out  1  upstream must not issue new write requests while high.
- pend  out  2^RW  bit r set while a write to register r is queued or in rf_* output.
- fifo_cnt  out  clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky error: a request was dropped.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - rf_we=0, rf_rd=0, rf_data=0.
  - FIFO emptied, fifo_cnt=0, pend=0, overflow=0.
  - stall=0 in the cycle after reset.
  - Reset overrides any request in the same cycle; queued writes are discarded.
- Candidates per cycle, in program order: FIFO head (oldest), then mem (older than ac in the same cycle), then ac.
- Exactly one candidate is granted per cycle: the first valid in that order.
- Granted write appears on rf_we/rf_rd/rf_data at the next rising edge (latency 1). rf_we=0 when nothing is granted. rf_rd/rf_data hold their last values when rf_we=0.
- Non-granted valid requests are enqueued at the tail in order mem then ac. The head is dequeued in the same cycle it is granted.
- Net occupancy growth is at most +1 per cycle:
  - empty FIFO, mem+ac valid: mem granted, ac enqueued.
  - non-empty FIFO, mem+ac valid: head granted, two entries enqueued.
- stall = (fifo_cnt >= DEPTH-1), combinational from registered count.
- Requests presented while stall=1 are not accepted; overflow sets and holds until reset.
- Requests while stall=0 must always be accepted without loss.
- Simultaneous enqueue and dequeue at the same occupancy is legal. Read/write pointers wrap modulo DEPTH; no bubble at wrap.
- Same-register ordering: two writes to the same rd commit in program order, guaranteed by the single ordered queue.
- pend[r]=1 iff r matches:
  - the rd of any valid FIFO entry, or
  - rf_rd while rf_we=1.
  
  pend is computed combinationally from registered state; same-cycle requests are not included.
- FIFO full with no requests: drains one entry per cycle; stall deasserts when fifo_cnt falls below DEPTH-1.
- Entry encoding is {src, rd, data}. The src bit is for debug only and has no effect on behaviour.

Decomposition:
- Shared package constants: DW, RW, register count (2^RW); source encoding SRC_MEM=1, SRC_AC=0.
- The entry record type (src, rd, data) also goes in the shared package.
- One sub-module: wb_fifo, a synchronous DEPTH-entry in-order queue.
  - Inputs: two write ports (push0/push1, in order), one pop, and clock/reset.
  - Exposes entries for pend generation.
- Grant logic, output registers, stall and scoreboard stay in wb_port_arbiter.

Test Plan:
- Single write: ac_we=1, ac_rd=2, ac_data=0x5A for one cycle, FIFO empty -> next cycle rf_we=1, rf_rd=2, rf_data=0x5A; pend[2]=1 that cycle; stall=0; fifo_cnt=0.
- Collision: mem(rd=1, 0x11) and ac(rd=3, 0x33) in the same cycle -> rf writes rd1=0x11 then rd3=0x33 on consecutive cycles; fifo_cnt 1 then 0; pend=0b1010 then 0b1000, then 0.
- Same-register order: mem(rd=0, 0xAA) and ac(rd=0, 0xBB) in the same cycle -> rf writes 0xAA then 0xBB to rd0. The final value is 0xBB.
- Back-pressure (DEPTH=4): mem+ac both valid every cycle while stall=0 -> fifo_cnt rises 1,2,3; stall=1 at cnt=3; no request lost; overflow=0. Release -> drains one per cycle and all writes appear in program order.
- Overflow: assert ac_we while stall=1 -> request not written; overflow=1 and remains 1 until reset.
- Reset mid-operation: fill FIFO to 3, assert reset for one cycle -> next cycle rf_we=0, fifo_cnt=0, pend=0, overflow=0, stall=0; no queued write emerges afterward.
